// File: rtl/pw_ram_arbiter.sv
// Single-port password RAM arbiter: round-robin between the command controller (r0) and memory controller (r1).
// Define PW_RAM_ARB_FIXED_PRIO_EN to make r0 always win contention (no rr_ptr).
module pw_ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 512,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("pw_ram_arbiter: RD_LATENCY must be in 1..4");
    end
  endgenerate

  logic gnt0;
  logic gnt1;
  logic win_we;

  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;

  logic                  r0_rvalid_q, r0_rvalid_d;
  logic                  r1_rvalid_q, r1_rvalid_d;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;

`ifdef PW_RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = rst_n && r0_valid;
    gnt1 = rst_n && r1_valid && !r0_valid;
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  // rr_ptr names the requester that wins when both are valid.
  always_comb begin
    gnt0     = rst_n && r0_valid && (!r1_valid || !rr_ptr_q);
    gnt1     = rst_n && r1_valid && (!r0_valid || rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
    if (gnt0) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    r0_ready  = gnt0;
    r1_ready  = gnt1;
    win_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      win_we    = r0_we;
      ram_addr  = r0_addr;
      ram_wdata = r0_wdata;
    end else if (gnt1) begin
      win_we    = r1_we;
      ram_addr  = r1_addr;
      ram_wdata = r1_wdata;
    end
    ram_en = gnt0 || gnt1;
    ram_we = ram_en && win_we;
  end

  // Tag pipeline mirrors the RAM read latency so the tail lines up with valid ram_rdata.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = ram_en && !win_we;
    tag_id_d[0]  = gnt1;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_comb begin
    r0_rvalid_d = tag_vld_q[RD_LATENCY-1] && !tag_id_q[RD_LATENCY-1];
    r1_rvalid_d = tag_vld_q[RD_LATENCY-1] && tag_id_q[RD_LATENCY-1];
    r0_rdata_d  = r0_rvalid_d ? ram_rdata : r0_rdata_q;
    r1_rdata_d  = r1_rvalid_d ? ram_rdata : r1_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule
